// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared state encoding and opcode constants for the TD4 run controller
package td4_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_RUN     = 2'b01,
        ST_HALTED  = 2'b10
    } state_t;

    localparam logic [3:0] OP_JMP = 4'b1111;

    // A JMP whose target is its own address never leaves; the program is finished.
    function automatic logic is_selfloop(input logic [7:0] order, input logic [3:0] pc);
        return (order[7:4] == OP_JMP) && (order[3:0] == pc);
    endfunction

endpackage

// File: rtl/td4_prescaler.sv
// rtl/td4_prescaler.sv - free-run pacing counter with divisor clamp and tick output
module td4_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] d;

    // A zero divisor is treated as one so ticks are always at least two cycles apart.
    always_comb begin
        d = (div == '0) ? ONE : div;
    end

    // >= rather than == so a divisor lowered mid-count still ticks promptly.
    assign tick = run && (cnt >= d);

    // Count while running; restart from zero on every tick and whenever idle or cleared.
    always_ff @(posedge clk) begin
        if (clr || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/td4_run_ctrl.sv
// rtl/td4_run_ctrl.sv - TD4 execution sequencer (run/step/stop, self-loop halt); optional breakpoint via TD4_BREAKPOINT_EN
module td4_run_ctrl
    import td4_pkg::*;
#(
    parameter int DIV_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             RUN_REQ,
    input  logic             STEP_REQ,
    input  logic             HALT_REQ,
    input  logic [DIV_W-1:0] DIV,
    input  logic [3:0]       PC,
    input  logic [7:0]       ORDER,
    output logic             EN,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] INSN_CNT
`ifdef TD4_BREAKPOINT_EN
    ,
    input  logic [3:0]       BP_ADDR,
    input  logic             BP_VALID,
    output logic             BP_HIT
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic             en_q;
    logic             en_d;
    logic             pre_clr;
    logic             tick;
    logic             selfloop;
    logic             bp_match;
    logic [CNT_W-1:0] insn_cnt_q;

    assign selfloop = is_selfloop(ORDER, PC);

`ifdef TD4_BREAKPOINT_EN
    logic bp_hit_q;

    assign bp_match = BP_VALID && (PC == BP_ADDR);

    // Sticky breakpoint flag: set when a run tick lands on the breakpoint, cleared by an accepted run/step.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            bp_hit_q <= 1'b0;
        end else if (state_q == ST_RUN && !HALT_REQ && tick && bp_match) begin
            bp_hit_q <= 1'b1;
        end else if (state_q == ST_STOPPED && (RUN_REQ || STEP_REQ)) begin
            bp_hit_q <= 1'b0;
        end
    end

    assign BP_HIT = bp_hit_q;
`else
    assign bp_match = 1'b0;
`endif

    td4_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (CLK),
        .clr  (CLR || pre_clr),
        .run  (state_q == ST_RUN),
        .div  (DIV),
        .tick (tick)
    );

    // Next-state and execute-strobe decision; priority halt > breakpoint > self-loop > execute.
    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        pre_clr = 1'b0;
        case (state_q)
            ST_STOPPED: begin
                if (RUN_REQ) begin
                    state_d = ST_RUN;
                    pre_clr = 1'b1;
                end else if (STEP_REQ) begin
                    en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (HALT_REQ) begin
                    state_d = ST_STOPPED;
                    pre_clr = 1'b1;
                end else if (tick) begin
                    if (bp_match) begin
                        state_d = ST_STOPPED;
                    end else if (selfloop) begin
                        state_d = ST_HALTED;
                    end else begin
                        en_d = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_STOPPED;
            end
        endcase
    end

    // State and execute-strobe registers.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= ST_STOPPED;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
        end
    end

    // Executed-instruction counter, one per EN cycle, wrapping naturally.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            insn_cnt_q <= '0;
        end else begin
            insn_cnt_q <= insn_cnt_q + CNT_W'(en_q);
        end
    end

    assign EN       = en_q;
    assign STATE    = state_q;
    assign INSN_CNT = insn_cnt_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb/tb_td4_run_ctrl.sv - scoreboard bench for td4_run_ctrl (EN timing, state, counter)
module tb_td4_run_ctrl;

    localparam int DIV_W = 24;
    localparam int CNT_W = 8;

    logic             CLK = 1'b0;
    logic             CLR = 1'b1;
    logic             RUN_REQ = 1'b0;
    logic             STEP_REQ = 1'b0;
    logic             HALT_REQ = 1'b0;
    logic [DIV_W-1:0] DIV = '0;
    logic [3:0]       PC = 4'd0;
    logic [7:0]       ORDER = 8'h00;
    logic             EN;
    logic [1:0]       STATE;
    logic [CNT_W-1:0] INSN_CNT;
`ifdef TD4_BREAKPOINT_EN
    logic [3:0]       BP_ADDR = 4'd0;
    logic             BP_VALID = 1'b0;
    logic             BP_HIT;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_q[$];

    td4_run_ctrl #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .RUN_REQ  (RUN_REQ),
        .STEP_REQ (STEP_REQ),
        .HALT_REQ (HALT_REQ),
        .DIV      (DIV),
        .PC       (PC),
        .ORDER    (ORDER),
        .EN       (EN),
        .STATE    (STATE),
        .INSN_CNT (INSN_CNT)
`ifdef TD4_BREAKPOINT_EN
        ,
        .BP_ADDR  (BP_ADDR),
        .BP_VALID (BP_VALID),
        .BP_HIT   (BP_HIT)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: every EN pulse must match the next expected cycle in the scoreboard.
    always @(negedge CLK) begin
        if (!CLR && EN === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_en: EN high at cycle %0d, none expected", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc != e) begin
                    bad++;
                    $display("FAIL en_cycle: EN at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
    endtask

    task automatic pulse(input logic run, input logic step, input logic halt);
        RUN_REQ  = run;
        STEP_REQ = step;
        HALT_REQ = halt;
        @(negedge CLK);
        RUN_REQ  = 1'b0;
        STEP_REQ = 1'b0;
        HALT_REQ = 1'b0;
    endtask

    initial begin
        int c0;
        int c1;
        @(negedge CLK);

        // 1: reset state, then free-run with DIV=3
        do_reset();
        check("reset_state", int'(STATE), 0);
        check("reset_en", int'(EN), 0);
        check("reset_cnt", int'(INSN_CNT), 0);
        DIV = 24'd3;
        ORDER = 8'h00;
        PC = 4'd0;
        c0 = cyc;
        exp_q.push_back(c0 + 5);
        exp_q.push_back(c0 + 9);
        exp_q.push_back(c0 + 13);
        pulse(1'b1, 1'b0, 1'b0);
        wait_until(c0 + 2);
        check("t1_state_run", int'(STATE), 1);
        wait_until(c0 + 14);
        check("t1_cnt", int'(INSN_CNT), 3);
        pulse(1'b0, 1'b0, 1'b1);
        check("t1_halted_to_stop", int'(STATE), 0);
        repeat (6) @(negedge CLK);

        // 2: single steps from STOPPED
        do_reset();
        c0 = cyc;
        wait_until(c0 + 2);
        exp_q.push_back(c0 + 3);
        pulse(1'b0, 1'b1, 1'b0);
        wait_until(c0 + 10);
        exp_q.push_back(c0 + 11);
        pulse(1'b0, 1'b1, 1'b0);
        wait_until(c0 + 13);
        check("t2_state", int'(STATE), 0);
        check("t2_cnt", int'(INSN_CNT), 2);

        // 3: self-loop detection parks in HALTED
        do_reset();
        DIV = 24'd1;
        ORDER = 8'hF5;
        PC = 4'd5;
        c0 = cyc;
        pulse(1'b1, 1'b0, 1'b0);
        wait_until(c0 + 4);
        check("t3_halted", int'(STATE), 2);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        check("t3_still_halted", int'(STATE), 2);
        check("t3_cnt", int'(INSN_CNT), 0);
        do_reset();
        check("t3_clr_exit", int'(STATE), 0);

        // 4: DIV=0 acts as 1; RUN+STEP together runs without an extra step; halt on a tick
        ORDER = 8'h00;
        PC = 4'd0;
        DIV = 24'd0;
        c0 = cyc;
        exp_q.push_back(c0 + 3);
        exp_q.push_back(c0 + 5);
        exp_q.push_back(c0 + 7);
        pulse(1'b1, 1'b1, 1'b0);
        wait_until(c0 + 8);
        pulse(1'b0, 1'b0, 1'b1);
        wait_until(c0 + 10);
        check("t4_state", int'(STATE), 0);
        check("t4_cnt", int'(INSN_CNT), 3);

        // 5: DIV=7, halt on a tick suppresses EN; restart waits a full D+1
        do_reset();
        DIV = 24'd7;
        c0 = cyc;
        exp_q.push_back(c0 + 9);
        pulse(1'b1, 1'b0, 1'b0);
        wait_until(c0 + 16);
        pulse(1'b0, 1'b0, 1'b1);
        check("t5_stopped", int'(STATE), 0);
        wait_until(c0 + 20);
        c1 = cyc;
        exp_q.push_back(c1 + 9);
        pulse(1'b1, 1'b0, 1'b0);
        wait_until(c1 + 10);
        pulse(1'b0, 1'b0, 1'b1);
        check("t5_cnt", int'(INSN_CNT), 2);

        // 5b: divisor lowered mid-count ticks at once
        do_reset();
        DIV = 24'd7;
        c0 = cyc;
        exp_q.push_back(c0 + 6);
        exp_q.push_back(c0 + 9);
        pulse(1'b1, 1'b0, 1'b0);
        wait_until(c0 + 5);
        DIV = 24'd2;
        wait_until(c0 + 10);
        pulse(1'b0, 1'b0, 1'b1);
        check("t5b_cnt", int'(INSN_CNT), 2);

`ifdef TD4_BREAKPOINT_EN
        // 6: breakpoint stops the run; a step at the breakpoint executes and clears the flag
        do_reset();
        DIV = 24'd1;
        BP_VALID = 1'b1;
        BP_ADDR = 4'd4;
        PC = 4'd3;
        c0 = cyc;
        exp_q.push_back(c0 + 3);
        pulse(1'b1, 1'b0, 1'b0);
        wait_until(c0 + 3);
        PC = 4'd4;
        wait_until(c0 + 5);
        check("t6_stopped", int'(STATE), 0);
        check("t6_bp_hit", int'(BP_HIT), 1);
        wait_until(c0 + 6);
        exp_q.push_back(c0 + 7);
        pulse(1'b0, 1'b1, 1'b0);
        wait_until(c0 + 8);
        check("t6_bp_clear", int'(BP_HIT), 0);
        check("t6_cnt", int'(INSN_CNT), 2);
        BP_VALID = 1'b0;
`endif

        repeat (4) @(negedge CLK);
        check("missing_en", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout at cycle %0d, expected completion", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/td4_run_ctrl.md
Name: td4_run_ctrl

Overview:
Execution sequencer for the TD4 4-bit CPU core. It drives the shared register enable (EN) for the A, B, OUT and PC registers, pacing instruction execution in three ways: free-run at a prescaled rate, single-step on request, or stop. It detects the program's terminal self-loop (JMP to own address) and parks the CPU in HALTED. It sits between the board-level buttons/debug logic and the td4 core.

Parameters:
DIV_W, 24, width of prescaler divisor and counter
CNT_W, 8, width of executed-instruction counter

Ports:
CLK  input  1  system clock; sole clock
CLR  input  1  synchronous active-high reset; also the CPU's register clear
RUN_REQ  input  1  one-cycle pulse: start free-running
STEP_REQ  input  1  one-cycle pulse: execute exactly one instruction
HALT_REQ  input  1  one-cycle pulse: stop free-running
DIV  input  DIV_W  prescaler divisor; live, sampled every cycle
PC  input  4  current PC from core
ORDER  input  8  current instruction word from ROM
EN  output  1  registered one-cycle execute strobe to all core registers
STATE  output  2  00 STOPPED, 01 RUN, 10 HALTED
INSN_CNT  output  CNT_W  count of EN pulses issued

Behaviour:
- Reset (CLR=1 at an edge): STATE=STOPPED, EN=0, prescaler cnt=0, INSN_CNT=0. CLR overrides all requests in the same cycle.
- D = max(DIV,1); DIV=0 behaves as 1. EN pulses are therefore never closer than 2 cycles, so PC is always updated before the next decision.
- selfloop = (ORDER[7:4]==OP_JMP) && (ORDER[3:0]==PC).
- STOPPED:
  - RUN_REQ: go to RUN, cnt<=0.
  - STEP_REQ without RUN_REQ: EN<=1 next cycle; stay STOPPED. Executes even when selfloop is true.
  - RUN_REQ and STEP_REQ in the same cycle: RUN wins; the step is dropped.
- RUN:
  - cnt increments each cycle. Tick when cnt>=D; the >= comparison covers DIV shrinking mid-count.
  - On a tick, cnt<=0. If selfloop: go to HALTED, EN stays 0. Otherwise EN<=1.
  - Timing: RUN_REQ accepted in cycle 0 gives first EN in cycle D+2, then one EN every D+1 cycles.
  - HALT_REQ: go to STOPPED, cnt<=0. An EN already registered still completes. HALT_REQ on a tick cycle suppresses that tick's EN.
  - HALT_REQ has priority over selfloop detection. RUN_REQ and STEP_REQ are ignored in RUN.
- HALTED: all requests ignored; only CLR exits.
- EN is high for exactly one cycle per issued instruction.
- INSN_CNT increments on every cycle EN=1 and wraps from 2^CNT_W-1 to 0.
- HALT_REQ in STOPPED is a no-op.

Optional Feature:
Macro TD4_BREAKPOINT_EN.
- Enabled: adds inputs BP_ADDR[3:0] and BP_VALID, and output BP_HIT.
  - In RUN, on a tick with BP_VALID && PC==BP_ADDR: go to STOPPED, no EN, BP_HIT<=1.
  - BP_HIT is sticky. It clears on CLR or on the next accepted RUN_REQ/STEP_REQ.
  - A STEP from STOPPED at the breakpoint address executes normally.
  - Breakpoint has priority over selfloop; HALT_REQ has priority over breakpoint.
- Disabled: no extra ports; behaviour exactly as above.

Decomposition:
- Shared package td4_pkg holds:
  - state encoding constants ST_STOPPED, ST_RUN, ST_HALTED
  - opcode constant OP_JMP=4'b1111
- One sub-module, td4_prescaler: cnt, the D clamp and the tick output, with a synchronous clear input.
- State machine, EN register and counter stay in td4_run_ctrl.

Test Plan:
1. Reset, DIV=3, RUN_REQ at cycle 0, ORDER=8'h00 -> EN in cycles 5, 9, 13; INSN_CNT=3 after cycle 13.
2. STOPPED, STEP_REQ pulses at cycles 2 and 10 -> EN exactly in cycles 3 and 11; STATE stays 00; INSN_CNT=2.
3. RUN with DIV=1, ORDER=8'hF5, PC=5 at a tick -> no EN, STATE=10; later RUN_REQ/STEP_REQ produce no EN; CLR -> STATE=00.
4. RUN with DIV=0 -> EN in alternate cycles only (period 2); RUN_REQ+STEP_REQ together from STOPPED -> RUN, no extra step EN.
5. RUN with DIV=7, HALT_REQ on a tick cycle -> no EN that tick, STATE=00; next RUN_REQ restarts with a full D+1 wait.
6. (TD4_BREAKPOINT_EN) BP_VALID=1, BP_ADDR=4, PC reaches 4 in RUN -> STOPPED, BP_HIT=1, no EN; STEP_REQ -> one EN, BP_HIT=0.
